// File: rtl/if_pkg.sv
// Shared types and constants for the fetch-to-decode buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

  localparam int INSTN_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTN_W-1:0] NOP_INSTN  = 32'h0000_0000;
  localparam logic [INSTN_W-1:0] HALT_INSTN = 32'hFFFF_FFFF;

  // One buffered fetch: the instruction, its own PC and the sequential successor PC.
  typedef struct packed {
    logic [INSTN_W-1:0] instn;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  nextpc;
  } if_entry_t;

  // True when the word handed to decode is the encoding that stops the front end.
  function automatic logic is_halt(input logic [INSTN_W-1:0] instn,
                                   input logic [INSTN_W-1:0] halt_code);
    return instn == halt_code;
  endfunction

endpackage

// File: rtl/if_fifo_mem.sv
// Entry storage for the IF/ID buffer: DEPTH entries, one write port, one async read port.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none here; the owner only asserts wr_en when a slot is free.
module if_fifo_mem
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  if_entry_t       wr_data,
  input  logic [AW-1:0]   rd_addr,
  output if_entry_t       rd_data
);

  if_entry_t mem_q [DEPTH];
  if_entry_t mem_d [DEPTH];

  // Next-state of the array: copy current contents, overlay the single write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage registers; cleared on reset so the head never reads as X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Asynchronous read of the head slot.
  always_comb begin
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode pipeline buffer: small FIFO of {instn, pc, nextpc} with flush and halt.
// Latency: one cycle from push edge to head visibility; no same-cycle fall-through.
// Backpressure: in_ready drops when full or halted (registered state only); head held while stall_flag.
module if_id_buffer #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] NOP_INSTN  = if_pkg::NOP_INSTN,
  parameter logic [31:0] HALT_INSTN = if_pkg::HALT_INSTN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instn,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_nextpc,
  input  logic        stall_flag,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_instn,
  output logic [31:0] out_pc,
  output logic [31:0] out_nextpc,
  output logic        halt,
  output logic [31:0] instn_count
);

  import if_pkg::*;

  // DEPTH must be a power of two >= 2 so the pointers wrap by natural overflow.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_q, halt_d;
  logic [31:0]   instn_count_q, instn_count_d;

  logic          push;
  logic          pop;
  logic          mem_we;
  if_entry_t     wr_entry;
  if_entry_t     head;

  if_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  // Handshake flags derived purely from registered state, never from stall_flag or flush.
  always_comb begin
    in_ready  = (count_q < FULL_CNT) && !halt_q;
    out_valid = (count_q != '0) && !halt_q;
    push      = in_valid && in_ready;
    pop       = out_valid && !stall_flag;
    wr_entry  = '{instn: in_instn, pc: in_pc, nextpc: in_nextpc};
  end

  // Next-state for pointers, occupancy, halt and the consumed-instruction counter.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    halt_d        = halt_q;
    instn_count_d = instn_count_q;
    mem_we        = 1'b0;

    if (flush && !halt_q) begin
      // Taken branch: drop the queue; a same-cycle push is discarded and a
      // same-cycle pop is squashed (no count, no halt detection).
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we = push;
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + AW'(1);
        instn_count_d = instn_count_q + 32'd1;
        if (is_halt(head.instn, HALT_INSTN)) begin
          halt_d = 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; synchronous reset overrides flush, push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      halt_q        <= 1'b0;
      instn_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      halt_q        <= halt_d;
      instn_count_q <= instn_count_d;
    end
  end

  // Head presentation: real entry when valid, otherwise NOP with zeroed PCs.
  always_comb begin
    if (out_valid) begin
      out_instn  = head.instn;
      out_pc     = head.pc;
      out_nextpc = head.nextpc;
    end else begin
      out_instn  = NOP_INSTN;
      out_pc     = '0;
      out_nextpc = '0;
    end
    halt        = halt_q;
    instn_count = instn_count_q;
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed stimulus feeding an expected-entry queue, monitor pops on each consume.
// Latency: checks the one-cycle push-to-head delay and flush/halt/reset timing.
// Backpressure: stall_flag driven directly; in_ready checked against hand-computed values.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instn;
  logic [31:0] in_pc;
  logic [31:0] in_nextpc;
  logic        stall_flag;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instn;
  logic [31:0] out_pc;
  logic [31:0] out_nextpc;
  logic        halt;
  logic [31:0] instn_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [95:0] exp_q[$];

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  if_id_buffer #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instn    (in_instn),
    .in_pc       (in_pc),
    .in_nextpc   (in_nextpc),
    .stall_flag  (stall_flag),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_instn   (out_instn),
    .out_pc      (out_pc),
    .out_nextpc  (out_nextpc),
    .halt        (halt),
    .instn_count (instn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a push and, when it is expected to be accepted, record it for the monitor.
  task automatic drive_push(input logic [31:0] instn, input logic [31:0] pc, input logic expect_accept);
    in_valid  = 1'b1;
    in_instn  = instn;
    in_pc     = pc;
    in_nextpc = pc + 32'd4;
    if (expect_accept) exp_q.push_back({instn, pc, pc + 32'd4});
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_instn  = 32'h0;
    in_pc     = 32'h0;
    in_nextpc = 32'h0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " in_ready"},    {31'b0, in_ready},  32'd1);
    check({tag, " out_valid"},   {31'b0, out_valid}, 32'd0);
    check({tag, " out_instn"},   out_instn,          32'h0000_0000);
    check({tag, " out_pc"},      out_pc,             32'd0);
    check({tag, " out_nextpc"},  out_nextpc,         32'd0);
    check({tag, " halt"},        {31'b0, halt},      32'd0);
    check({tag, " instn_count"}, instn_count,        32'd0);
  endtask

  // Monitor: every non-squashed consume must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && !stall_flag) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got pc %h, expected no output", out_pc);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        check("pop instn",  out_instn,  e[95:64]);
        check("pop pc",     out_pc,     e[63:32]);
        check("pop nextpc", out_nextpc, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_flag = 1'b0; flush = 1'b0;
    idle_in();
    tick(); tick();
    check_reset_state("reset");

    // Basic push then pop.
    reset = 1'b0; stall_flag = 1'b1;
    drive_push(32'h2001_0005, 32'd0, 1'b1);
    tick();
    idle_in();
    check("basic out_valid",  {31'b0, out_valid}, 32'd1);
    check("basic out_pc",     out_pc,             32'd0);
    check("basic out_nextpc", out_nextpc,         32'd4);
    check("basic out_instn",  out_instn,          32'h2001_0005);
    stall_flag = 1'b0;
    tick();
    check("basic instn_count", instn_count,       32'd1);
    check("basic empty instn", out_instn,         32'h0000_0000);
    check("basic empty valid", {31'b0, out_valid}, 32'd0);

    // Fill while stalled; third push must be ignored.
    stall_flag = 1'b1;
    drive_push(32'h1111_0000, 32'd0, 1'b1); tick();
    drive_push(32'h1111_0004, 32'd4, 1'b1); tick();
    check("fill in_ready full", {31'b0, in_ready}, 32'd0);
    drive_push(32'h1111_0008, 32'd8, 1'b0); tick();
    idle_in();
    check("fill head held", out_pc, 32'd0);
    stall_flag = 1'b0;
    tick(); tick();
    check("fill drained valid", {31'b0, out_valid}, 32'd0);
    check("fill instn_count",   instn_count,        32'd3);

    // Streaming push+pop at occupancy 1, pc 0..28.
    for (int i = 0; i < 8; i++) begin
      drive_push(32'h3000_0000 + i, 32'(i * 4), 1'b1);
      tick();
      if (i == 4) begin
        check("stream in_ready",  {31'b0, in_ready},  32'd1);
        check("stream out_valid", {31'b0, out_valid}, 32'd1);
        check("stream head pc",   out_pc,             32'd16);
      end
    end
    idle_in();
    tick();
    check("stream instn_count", instn_count,        32'd11);
    check("stream empty",       {31'b0, out_valid}, 32'd0);

    // Flush with head pc=8 and a same-cycle push of pc=12.
    stall_flag = 1'b1;
    drive_push(32'h4000_0008, 32'd8, 1'b1); tick();
    stall_flag = 1'b0; flush = 1'b1;
    drive_push(32'h4000_000C, 32'd12, 1'b0);
    exp_q.delete();
    tick();
    flush = 1'b0; idle_in();
    check("flush out_valid",   {31'b0, out_valid}, 32'd0);
    check("flush instn_count", instn_count,        32'd11);
    check("flush in_ready",    {31'b0, in_ready},  32'd1);
    stall_flag = 1'b1;
    drive_push(32'h4000_0028, 32'd40, 1'b1); tick();
    idle_in();
    check("post-flush valid", {31'b0, out_valid}, 32'd1);
    check("post-flush pc",    out_pc,             32'd40);
    stall_flag = 1'b0;
    tick();
    check("post-flush count", instn_count, 32'd12);

    // Halt.
    stall_flag = 1'b1;
    drive_push(HALT_W, 32'd32, 1'b1); tick();
    idle_in(); stall_flag = 1'b0;
    tick();
    check("halt halt",        {31'b0, halt},      32'd1);
    check("halt in_ready",    {31'b0, in_ready},  32'd0);
    check("halt out_valid",   {31'b0, out_valid}, 32'd0);
    check("halt out_instn",   out_instn,          32'h0000_0000);
    check("halt instn_count", instn_count,        32'd13);
    drive_push(32'h5000_002C, 32'd44, 1'b0); tick(); tick();
    idle_in();
    check("halted out_valid", {31'b0, out_valid}, 32'd0);
    check("halted count",     instn_count,        32'd13);
    check("halted sticky",    {31'b0, halt},      32'd1);

    // Reset clears halt.
    reset = 1'b1; tick();
    reset = 1'b0;
    check_reset_state("halt-reset");

    // Flush and halt in the same cycle: flush wins.
    stall_flag = 1'b1;
    drive_push(HALT_W, 32'd48, 1'b1); tick();
    idle_in(); stall_flag = 1'b0; flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    check("flush-halt halt",  {31'b0, halt},      32'd0);
    check("flush-halt count", instn_count,        32'd0);
    check("flush-halt ready", {31'b0, in_ready},  32'd1);

    // Reset mid-stream with two entries buffered.
    stall_flag = 1'b1;
    drive_push(32'h6000_0064, 32'd100, 1'b1); tick();
    drive_push(32'h6000_0068, 32'd104, 1'b1); tick();
    idle_in();
    check("mid full ready", {31'b0, in_ready}, 32'd0);
    check("mid head pc",    out_pc,            32'd100);
    reset = 1'b1; stall_flag = 1'b0; flush = 1'b1;
    drive_push(32'h6000_006C, 32'd108, 1'b0);
    exp_q.delete();
    tick();
    reset = 1'b0; flush = 1'b0; idle_in();
    check_reset_state("mid-reset");
    tick();

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
